uart_state_tx: RTL and testbench

- Transmit-side counterpart to the game's UART key receiver.
- Serialises a 32-bit game-state word (HP bars, status flags) as a framed packet on RsTx, so a host PC can log and mirror the battle.
- Sits beside the UART receiver in the top level and is fed the same 32-bit state word that drives the VGA renderer.
- 8N1 format, LSB first.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_byte.sv | 113 +++++++++++
 rtl/uart_state_tx.sv | 112 +++++++++++
 tb/tb_uart_state_tx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte-FSM state encoding,
// default bit timing and the frame sync byte.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // 100 MHz system clock / 9600 baud
  localparam int CLKS_PER_BIT_DEFAULT = 10417;

  // First byte of every state frame, lets the host resynchronise
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 transmitter (LSB first). Owns the bit timer and byte FSM.
// ready is high in IDLE and in the last cycle of the stop bit, so a go
// presented then chains the next start bit with no gap cycle.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       go,
  input  logic [7:0] data,
  output logic       TX,
  output logic       ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  assign TX    = tx_q;
  assign ready = (state_q == UART_IDLE) || ((state_q == UART_STOP) && (cnt_q == '0));

  // Control state: FSM, bit timer, bit index and the registered line driver
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Byte shift register; data only, needs no reset
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  // Next-state logic: each bit lasts CNT_MAX+1 cycles of the down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (go) begin
          state_d = UART_START;
          cnt_d   = CNT_MAX;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          state_d = UART_DATA;
          cnt_d   = CNT_MAX;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          bit_d   = bit_q + 3'd1;   // wraps 7 -> 0 on the way into STOP
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          if (go) begin
            state_d = UART_START;
            cnt_d   = CNT_MAX;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = UART_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_state_tx.sv
// Game-state frame transmitter: sends SYNC_BYTE then the 32-bit state word
// MSB byte first over an 8N1 line. Optional trailing XOR checksum byte is
// enabled by defining UART_STATE_TX_CHECKSUM_EN.
module uart_state_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        send,
  input  logic [31:0] state,
  output logic        TX,
  output logic        busy,
  output logic        done
);

`ifdef UART_STATE_TX_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic        go;
  logic [7:0]  go_data;
  logic        ready;
  logic [2:0]  idx_nxt;

  // Byte to transmit at a given frame position
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] w);
    logic [7:0] b;
    case (idx)
      3'd1:    b = w[31:24];
      3'd2:    b = w[23:16];
      3'd3:    b = w[15:8];
      3'd4:    b = w[7:0];
`ifdef UART_STATE_TX_CHECKSUM_EN
      3'd5:    b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

  assign busy    = busy_q;
  assign done    = done_q;
  assign idx_nxt = idx_q + 3'd1;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .CLK  (CLK),
    .RESET(RESET),
    .go   (go),
    .data (go_data),
    .TX   (TX),
    .ready(ready)
  );

  // Frame control registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
    end
  end

  // Shadow copy of the state word, frozen for the frame in flight
  always_ff @(posedge CLK) begin
    shadow_q <= shadow_d;
  end

  // Frame sequencing: accept when idle, chain bytes at each stop-bit end
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    go       = 1'b0;
    go_data  = SYNC_BYTE;
    if (!busy_q) begin
      if (send) begin
        go       = 1'b1;
        go_data  = SYNC_BYTE;
        shadow_d = state;
        busy_d   = 1'b1;
        idx_d    = 3'd0;
      end
    end else if (ready) begin
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        go      = 1'b1;
        go_data = frame_byte(idx_nxt, shadow_q);
        idx_d   = idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_state_tx.sv
// Directed self-checking bench for uart_state_tx at 4 clocks per bit.
module tb_uart_state_tx;

  localparam int CPB = 4;
`ifdef UART_STATE_TX_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int TOT = NB * 10 * CPB;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        send;
  logic [31:0] state;
  logic        TX, busy, done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  uart_state_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .send (send),
    .state(state),
    .TX   (TX),
    .busy (busy),
    .done (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the
  // negedge of the done cycle. inj >= 0 pulses a rejected send mid-frame.
  task automatic decode_frame(input logic [31:0] st, input int inj, input string tag);
    logic [9:0] fb [NB];
    logic [7:0] eb [NB];
    bit ctl_bad;
    ctl_bad = 1'b0;
    eb[0] = 8'hA5;
    eb[1] = st[31:24];
    eb[2] = st[23:16];
    eb[3] = st[15:8];
    eb[4] = st[7:0];
`ifdef UART_STATE_TX_CHECKSUM_EN
    eb[5] = st[31:24] ^ st[23:16] ^ st[15:8] ^ st[7:0];
`endif
    check($sformatf("%s_sof", tag), {30'd0, TX, busy}, 32'h1);
    for (int c = 0; c < TOT; c++) begin
      if (c % CPB == CPB / 2) fb[c / (10 * CPB)][(c / CPB) % 10] = TX;
      if (busy !== 1'b1 || done !== 1'b0) ctl_bad = 1'b1;
      if (inj >= 0 && c == inj) begin send = 1'b1; state = 32'hFFFF_FFFF; end
      if (inj >= 0 && c == inj + 1) begin send = 1'b0; state = 32'h0; end
      @(negedge CLK);
    end
    check($sformatf("%s_done", tag), {29'd0, TX, busy, done}, 32'h5);
    check($sformatf("%s_ctl", tag), {31'd0, ctl_bad}, 32'h0);
    for (int b = 0; b < NB; b++)
      check($sformatf("%s_byte%0d", tag, b), {22'd0, fb[b]}, {22'd0, 1'b1, eb[b], 1'b0});
  endtask

  // Pulse send for one cycle, then scramble state to prove it was shadowed
  task automatic start_frame(input logic [31:0] st);
    @(negedge CLK);
    send  = 1'b1;
    state = st;
    @(negedge CLK);
    send  = 1'b0;
    state = 32'hDEAD_BEEF;
  endtask

  initial begin
    bit idle_bad;
    bit post_bad;
    RESET = 1'b1;
    send  = 1'b0;
    state = 32'h0;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_vals", {29'd0, TX, busy, done}, 32'h4);
    RESET = 1'b0;

    // Idle for 1000 cycles with no send
    idle_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
    end
    check("idle_1000", {31'd0, idle_bad}, 32'h0);

    // Single frame
    start_frame(32'h903C_6400);
    decode_frame(32'h903C_6400, -1, "single");
    @(negedge CLK);
    check("single_after", {29'd0, TX, busy, done}, 32'h4);

    // Send while busy is ignored, not queued, frame unchanged
    start_frame(32'h1122_3344);
    decode_frame(32'h1122_3344, 60, "busyign");
    post_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0) post_bad = 1'b1;
    end
    check("busyign_noqueue", {31'd0, post_bad}, 32'h0);

    // Back-to-back with send held high
    @(negedge CLK);
    send  = 1'b1;
    state = 32'hA55A_0FF0;
    @(negedge CLK);
    decode_frame(32'hA55A_0FF0, -1, "b2b1");
    @(negedge CLK);
    send = 1'b0;
    decode_frame(32'hA55A_0FF0, -1, "b2b2");
    @(negedge CLK);
    check("b2b_after", {29'd0, TX, busy, done}, 32'h4);

    // Asynchronous reset during byte 2, data bit 3 (line low there)
    start_frame(32'h1200_3456);
    repeat (97) @(negedge CLK);
    check("rst_mid_pre_tx", {31'd0, TX}, 32'h0);
    #1 RESET = 1'b1;
    #1 check("rst_mid_async", {29'd0, TX, busy, done}, 32'h4);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_after", {29'd0, TX, busy, done}, 32'h4);
    start_frame(32'h903C_6400);
    decode_frame(32'h903C_6400, -1, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
